// File: rtl/seg_scan_4dig.sv
// rtl/seg_scan_4dig.sv - time-multiplexed 4-digit 7-segment scanner with dp, blanking and dead time
module seg_scan_4dig #(
    parameter int SCAN_DIV    = 24000,
    parameter int DEAD_CYC    = 2,
    parameter int DP_DIGIT    = 1,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] qian,
    input  logic [3:0] bai,
    input  logic [3:0] shi,
    input  logic [3:0] ge,
    input  logic       lz_en,
    output logic [7:0] seg,
    output logic [3:0] sel
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam int BLANK_MIN = (DP_DIGIT >= 4) ? 0 : DP_DIGIT;
    localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] SEL_OFF = SEL_ACT_LOW ? 4'hF : 4'h0;

    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [3:0][3:0] shd;
    logic            loaded;

    logic [3:0][3:0] in_dig;
    logic [3:0][3:0] cur_dig;
    logic [3:0]      upper_zero;
    logic            slot_end;
    logic            frame_end;
    logic            dead;
    logic [3:0]      val;
    logic [6:0]      glyph;
    logic            blank;
    logic [7:0]      pat;
    logic [3:0]      sel_act;
    logic [7:0]      seg_d;
    logic [3:0]      sel_d;

    assign in_dig    = {qian, bai, shi, ge};
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);
    // The very first displayed cycle after reset uses the digits being captured on that edge.
    assign cur_dig   = loaded ? shd : in_dig;
    assign dead      = (int'(cnt) < DEAD_CYC);
    assign val       = cur_dig[idx];

    always_comb begin
        upper_zero[3] = (cur_dig[3] == 4'd0);
        for (int k = 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (cur_dig[k] == 4'd0);
        end
    end

    always_comb begin
        case (val)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    end

    always_comb begin
        blank   = lz_en && (int'(idx) > BLANK_MIN) && upper_zero[idx];
        pat     = 8'h00;
        sel_act = 4'h0;
        if (!dead) begin
            pat[7]   = (int'(idx) == DP_DIGIT);
            pat[6:0] = blank ? 7'h00 : glyph;
            sel_act  = 4'b0001 << idx;
        end
        seg_d = SEG_ACT_LOW ? ~pat : pat;
        sel_d = SEL_ACT_LOW ? ~sel_act : sel_act;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 2'd0;
            shd    <= '0;
            loaded <= 1'b0;
            seg    <= SEG_OFF;
            sel    <= SEL_OFF;
        end else begin
            cnt    <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (!loaded || frame_end) begin
                shd <= in_dig;
            end
            loaded <= 1'b1;
            seg    <= seg_d;
            sel    <= sel_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_4dig.sv
// tb/tb_seg_scan_4dig.sv - randomized self-checking bench for seg_scan_4dig against a timeline model
module tb_seg_scan_4dig;
    localparam int SD   = 8;
    localparam int DEAD = 2;
    localparam int DP   = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] qian, bai, shi, ge;
    logic       lz_en;
    logic [7:0] seg;
    logic [3:0] sel;

    int checks = 0;
    int errors = 0;

    seg_scan_4dig #(
        .SCAN_DIV(SD), .DEAD_CYC(DEAD), .DP_DIGIT(DP), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .qian(qian), .bai(bai), .shi(shi), .ge(ge),
        .lz_en(lz_en), .seg(seg), .sel(sel)
    );

    always #5 clk = ~clk;

    // Model: t counts displayed cycles since reset release; all slot/frame timing derives from t.
    bit         mvalid = 1'b0;
    int         t = -1;
    int         m_digit = -1;
    int         m_pos = -1;
    logic [3:0] snap [4];
    logic [7:0] exp_seg;
    logic [3:0] exp_sel;

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mvalid  = 1'b1;
            t       = -1;
            m_digit = -1;
            m_pos   = -1;
            exp_seg = 8'hFF;
            exp_sel = 4'hF;
        end else if (mvalid) begin
            t = t + 1;
            if (t == 0) begin
                snap[0] = ge; snap[1] = shi; snap[2] = bai; snap[3] = qian;
            end
            m_digit = (t / SD) % 4;
            m_pos   = t % SD;
            if (m_pos < DEAD) begin
                exp_seg = 8'hFF;
                exp_sel = 4'hF;
            end else begin
                bit         all_zero;
                logic [7:0] p;
                all_zero = 1'b1;
                for (int k = m_digit; k < 4; k++) begin
                    if (snap[k] != 4'd0) all_zero = 1'b0;
                end
                p[7]   = (m_digit == DP);
                p[6:0] = (lz_en && m_digit > DP && all_zero) ? 7'h00 : glyph_of(snap[m_digit]);
                exp_seg = ~p;
                exp_sel = ~(4'b0001 << m_digit);
            end
            if (t % (4 * SD) == 4 * SD - 1) begin
                snap[0] = ge; snap[1] = shi; snap[2] = bai; snap[3] = qian;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] eseg, input logic [3:0] esel);
        checks++;
        if (seg !== eseg || sel !== esel) begin
            errors++;
            $display("FAIL %s t=%0d seg=%h expected %h sel=%h expected %h", name, t, seg, eseg, sel, esel);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (mvalid) chk("model", exp_seg, exp_sel);
    end

    task automatic set_in(input logic [3:0] q, input logic [3:0] b, input logic [3:0] s, input logic [3:0] g);
        qian = q; bai = b; shi = s; ge = g;
    endtask

    task automatic wait_at(input int d, input int pos, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            if (m_digit == d && m_pos == pos) ok = 1'b1;
        end
    endtask

    task automatic lit(input string name, input int d, input logic [7:0] eseg, input logic [3:0] esel);
        bit ok;
        wait_at(d, DEAD, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for digit %0d", name, d);
        end else begin
            chk(name, eseg, esel);
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        lz_en = 1'b1;
        set_in(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset", 8'hFF, 4'hF);

        set_in(0, 3, 6, 5);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("first_slot", (i < 2) ? 8'hFF : 8'h92, (i < 2) ? 4'hF : 4'hE);
        end
        lit("d1_036.5", 1, 8'h02, 4'hD);
        lit("d2_036.5", 2, 8'hB0, 4'hB);
        lit("d3_036.5", 3, 8'hFF, 4'h7);

        set_in(0, 0, 0, 0);
        lit("d0_zero", 0, 8'hC0, 4'hE);
        lit("d1_zero", 1, 8'h40, 4'hD);
        lit("d2_zero_blank", 2, 8'hFF, 4'hB);
        lit("d3_zero_blank", 3, 8'hFF, 4'h7);
        lz_en = 1'b0;
        lit("d2_zero_lz0", 2, 8'hC0, 4'hB);
        lit("d3_zero_lz0", 3, 8'hC0, 4'h7);

        lz_en = 1'b1;
        set_in(1, 2, 3, 4);
        lit("d0_1234", 0, 8'h99, 4'hE);
        lit("d1_1234", 1, 8'h30, 4'hD);
        set_in(5, 6, 7, 8);
        lit("d2_old", 2, 8'hA4, 4'hB);
        lit("d3_old", 3, 8'hF9, 4'h7);
        lit("d0_new", 0, 8'h80, 4'hE);

        set_in(0, 4'hA, 0, 4'hC);
        lit("d3_prev", 3, 8'h92, 4'h7);
        lit("d0_dash", 0, 8'hBF, 4'hE);
        lit("d1_dp0", 1, 8'h40, 4'hD);
        lit("d2_dash", 2, 8'hBF, 4'hB);
        lit("d3_blank", 3, 8'hFF, 4'h7);

        set_in(9, 8, 7, 6);
        lit("d0_9876", 0, 8'h82, 4'hE);
        wait_at(2, 4, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL midslot_wait timeout");
        end
        rst_n = 1'b0;
        set_in(1, 0, 0, 2);
        @(negedge clk);
        chk("midslot_reset", 8'hFF, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_dead", 8'hFF, 4'hF);
        lit("restart_d0", 0, 8'hA4, 4'hE);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
            end else if (!rst_n && $urandom_range(0, 1) == 0) begin
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) begin
                qian = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                bai  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                shi  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                ge   = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
